shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, bits per state byte.
REQ-002 SHALL have parameter NB, default 4, state columns; legal values 4, 6 and 8, others rejected at elaboration.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input state present.
REQ-006 SHALL have port in_ready  output  1  block can accept a state.
REQ-007 SHALL have port in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with in_data.
REQ-008 SHALL have port in_data  input  WORD_SIZE*4*NB  input state, MSB-first ([0:N-1]).
REQ-009 SHALL have port out_valid  output  1  head result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head.
REQ-011 SHALL have port out_data  output  WORD_SIZE*4*NB  head result.
REQ-012 SHALL have port done  output  1  one-cycle pulse per output transfer.

Function
REQ-013 State byte (row r, column c) SHALL occupy bits [(4*c+r)*WORD_SIZE +: WORD_SIZE], column-major, bit 0 MSB.
REQ-014 Row offsets C_r SHALL be: row0 = 0; NB 4 or 6: 1,2,3; NB 8: 1,3,4.
REQ-015 Forward: out[r][c] = in[r][(c+C_r) mod NB].
REQ-016 Inverse: out[r][(c+C_r) mod NB] = in[r][c].
REQ-017 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; the transformed state SHALL be written to a 2-entry FIFO at that edge.
REQ-018 Latency: a state accepted at edge t SHALL be visible with out_valid=1 from edge t onward (next cycle) when the FIFO was empty.
REQ-019 in_ready SHALL equal (count != 2), from registered count only; no combinational path from out_ready to in_ready.
REQ-020 Output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; head pops.
REQ-021 out_valid SHALL equal (count != 0); out_data SHALL be the FIFO head, held stable while out_valid=1 and out_ready=0.
REQ-022 Results SHALL leave in acceptance order; per-entry mode honoured independently.
REQ-023 Simultaneous push and pop with count=1 SHALL keep count 1 and make the new entry the head after the edge.
REQ-024 Simultaneous push and pop at count=0 SHALL be impossible (out_valid=0); push at count=2 SHALL be impossible (in_ready=0).
REQ-025 done SHALL be registered, high for exactly the cycle following each output transfer, low otherwise.
REQ-026 out_data SHALL read all-zero when count=0.

Reset
REQ-027 With rst=0 at a rising edge: count=0, FIFO entries zeroed, out_valid=0, out_data=0, done=0, in_ready=1 after the edge.
REQ-028 Reset mid-operation SHALL discard all buffered states; a transfer coinciding with reset SHALL be ignored.

Configuration
REQ-029 Macro SHIFT_ROWS_INV_EN defined: in_inv selects inverse per REQ-016.
REQ-030 Macro SHIFT_ROWS_INV_EN undefined: in_inv ignored, forward only, no inverse logic or per-entry mode storage synthesised.

Verification
REQ-031 NB=4, forward: in_data=0xd42711aee0bf98f1b8b45de51e415230 -> out_data=0xd4bf5d30e0b452aeb84111f11e2798e5, out_valid next cycle, done one cycle after pop.
REQ-032 NB=4, SHIFT_ROWS_INV_EN, in_inv=1: in_data=0xd4bf5d30e0b452aeb84111f11e2798e5 -> out_data=0xd42711aee0bf98f1b8b45de51e415230.
REQ-033 NB=8, forward, byte k=k (0x00..0x1f): row1 column0 result=0x05, row3 column0 result=0x13.
REQ-034 out_ready=0, push 3 states back-to-back -> first two accepted, in_ready=0 on third until one pop; outputs in order.
REQ-035 count=1, in_valid=1 and out_ready=1 same cycle -> count stays 1, old head popped, new head correct, done pulses once.
REQ-036 Two states buffered, rst=0 one cycle -> out_valid=0, out_data=0, in_ready=1, done=0; no stale output afterwards.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
//
// Rijndael ShiftRows / InvShiftRows stage followed by a 2-entry output FIFO.
// The state is transformed on the way in, so each FIFO entry already holds
// its finished result. Entries therefore never need to remember their mode.
//
// State layout: byte (row r, column c) sits at bits
// [(4*c+r)*WORD_SIZE +: WORD_SIZE] of an MSB-first vector. Bit 0 is the MSB,
// and the bytes are stored column by column.
//
// Parameters
//   WORD_SIZE  bits per state byte (default 8)
//   NB         state columns, 4, 6 or 8 (default 4)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   input state present
//   in_ready   a state can be accepted (FIFO not full, from registered count)
//   in_inv     1 = InvShiftRows, 0 = ShiftRows, sampled with in_data
//   in_data    input state, WORD_SIZE*4*NB bits
//   out_valid  FIFO head present
//   out_ready  consumer takes the head
//   out_data   FIFO head, all-zero when the FIFO is empty
//   done       one-cycle pulse in the cycle after each output transfer
//
// Build option
//   SHIFT_ROWS_INV_EN  when defined, in_inv selects the inverse shift.
//                      When undefined, in_inv is ignored and only the
//                      forward wiring exists.
// ---------------------------------------------------------------------------

// One state row, rotated left by OFF for forward or right by OFF for inverse.
module shift_rows_row #(
  parameter int WORD_SIZE = 8,
  parameter int NB        = 4,
  parameter int OFF       = 0
) (
  input  logic [0:NB*WORD_SIZE-1] row_i,
`ifdef SHIFT_ROWS_INV_EN
  input  logic                    inv_i,
`endif
  output logic [0:NB*WORD_SIZE-1] row_o
);
  logic [0:NB*WORD_SIZE-1] fwd;
`ifdef SHIFT_ROWS_INV_EN
  logic [0:NB*WORD_SIZE-1] inv;
`endif

  for (genvar c = 0; c < NB; c++) begin : g_col
    // forward: out[c] = in[(c+OFF) mod NB]
    localparam int FSRC = (c + OFF) % NB;
    assign fwd[c*WORD_SIZE +: WORD_SIZE] = row_i[FSRC*WORD_SIZE +: WORD_SIZE];
`ifdef SHIFT_ROWS_INV_EN
    // inverse: out[(c+OFF) mod NB] = in[c], i.e. out[c] = in[(c-OFF) mod NB]
    localparam int ISRC = (c + NB - OFF) % NB;
    assign inv[c*WORD_SIZE +: WORD_SIZE] = row_i[ISRC*WORD_SIZE +: WORD_SIZE];
`endif
  end

`ifdef SHIFT_ROWS_INV_EN
  assign row_o = inv_i ? inv : fwd;
`else
  assign row_o = fwd;
`endif
endmodule

module shift_rows_pipe #(
  parameter int WORD_SIZE = 8,
  parameter int NB        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_inv,
  input  logic [0:WORD_SIZE*4*NB-1] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:WORD_SIZE*4*NB-1] out_data,
  output logic                      done
);
  localparam int N  = WORD_SIZE * 4 * NB;
  localparam int RW = WORD_SIZE * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Rijndael row offsets. The wide block (NB=8) uses 1,3,4 for rows 1..3.
  function automatic int row_off(input int r);
    if (r == 0)       return 0;
    else if (NB != 8) return r;
    else if (r == 1)  return 1;
    else if (r == 2)  return 3;
    else              return 4;
  endfunction

  // -------------------------------------------------------------------------
  // Transform: regroup the column-major input into rows, rotate each row,
  // then regroup back into columns.
  // -------------------------------------------------------------------------
  logic [3:0][0:RW-1] row_in;
  logic [3:0][0:RW-1] row_out;
  logic [0:N-1]       xf_data;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      assign row_in[r][c*WORD_SIZE +: WORD_SIZE] =
        in_data[(4*c+r)*WORD_SIZE +: WORD_SIZE];
      assign xf_data[(4*c+r)*WORD_SIZE +: WORD_SIZE] =
        row_out[r][c*WORD_SIZE +: WORD_SIZE];
    end

    shift_rows_row #(
      .WORD_SIZE (WORD_SIZE),
      .NB        (NB),
      .OFF       (row_off(r))
    ) u_row (
      .row_i (row_in[r]),
`ifdef SHIFT_ROWS_INV_EN
      .inv_i (in_inv),
`endif
      .row_o (row_out[r])
    );
  end

`ifndef SHIFT_ROWS_INV_EN
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // -------------------------------------------------------------------------
  // 2-entry FIFO, addressed by two ring pointers plus an occupancy count.
  // -------------------------------------------------------------------------
  logic [0:N-1] mem_q [2];
  logic [0:N-1] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         done_q, done_d;
  logic         push, pop;

  // Both handshakes depend only on the registered count. This keeps
  // out_ready from having a combinational path to in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign done      = done_q;

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    done_d   = pop;
    if (push) mem_d[wr_ptr_q] = xf_data;
    // At count 1, a push and a pop together leave the count unchanged.
    // The pointer moves make the new entry the head.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Reset takes priority, so a transfer in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;
`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef logic [0:127] st_t;
  typedef struct {
    st_t  din;
    logic inv;
    st_t  exp_fwd;
    st_t  exp_inv;
  } vec_t;

  logic clk, rst;

  // NB=4 instance
  logic in_valid, in_ready, in_inv, out_valid, out_ready, done;
  st_t  in_data, out_data;

  // NB=8 instance
  logic in_valid8, in_ready8, out_valid8, out_ready8, done8;
  logic [0:255] in_data8, out_data8;

  int checks = 0;
  int errors = 0;
  st_t  sb[$];
  vec_t vecs[6];

  shift_rows_pipe #(.WORD_SIZE(8), .NB(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done(done)
  );

  shift_rows_pipe #(.WORD_SIZE(8), .NB(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_inv(1'b0), .in_data(in_data8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic st_t exp_of(input vec_t v);
    return (INV_EN && v.inv) ? v.exp_inv : v.exp_fwd;
  endfunction

  // One clock of the NB=4 DUT. The scoreboard decides from its own occupancy
  // whether a push or pop happens at this edge. After the edge, the DUT is
  // checked against that occupancy.
  task automatic tick(input string tag, input st_t exp_push);
    bit push, pop;
    push = rst && in_valid  && (sb.size() != 2);
    pop  = rst && out_ready && (sb.size() != 0);
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(exp_push);
    if (!rst) sb.delete();
    @(posedge clk);
    #1;
    chk({tag, " done"},      {255'd0, done},      {255'd0, pop});
    chk({tag, " out_valid"}, {255'd0, out_valid}, {255'd0, sb.size() != 0});
    chk({tag, " in_ready"},  {255'd0, in_ready},  {255'd0, sb.size() != 2});
    if (sb.size() != 0) chk({tag, " out_data"}, {128'd0, out_data}, {128'd0, sb[0]});
    else                chk({tag, " out_data0"}, {128'd0, out_data}, 256'd0);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.din;
    in_inv   = v.inv;
  endtask

  initial begin
    int off8 [4];
    logic [0:255] exp8;
    logic [7:0] b;

    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
                128'hd4b411e5e0419830b8275dae1ebf52f1, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                128'h00050a0f04090e03080d02070c01060b, 128'h00050a0f04090e03080d02070c01060b};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                128'h00050a0f04090e03080d02070c01060b, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[4] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd4415df1e02752e5b8bf11301eb498ae};
    vecs[5] = '{{128{1'b1}}, 1'b0, {128{1'b1}}, {128{1'b1}}};

    rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;

    // Reset state
    tick("reset0", '0);
    tick("reset1", '0);
    rst = 1'b1;
    tick("idle", '0);

    // Streaming table: push and pop together at count 1 every cycle
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      tick($sformatf("vec%0d", i), exp_of(vecs[i]));
    end
    in_valid = 1'b0;
    tick("drain0", '0);
    tick("drain1", '0);

    // Full FIFO back-pressure: the third state waits until a pop
    out_ready = 1'b0;
    drive(vecs[0]); tick("bp_a", exp_of(vecs[0]));
    drive(vecs[2]); tick("bp_b", exp_of(vecs[2]));
    drive(vecs[4]); tick("bp_c_blk0", exp_of(vecs[4]));
    tick("bp_c_blk1", exp_of(vecs[4]));
    out_ready = 1'b1;
    tick("bp_pop_a", exp_of(vecs[4]));
    tick("bp_c_acc", exp_of(vecs[4]));
    in_valid = 1'b0;
    tick("bp_drain0", '0);
    tick("bp_drain1", '0);

    // Reset with two states buffered; the transfer in the reset cycle is dropped
    out_ready = 1'b0;
    drive(vecs[1]); tick("mr_a", exp_of(vecs[1]));
    drive(vecs[3]); tick("mr_b", exp_of(vecs[3]));
    drive(vecs[5]); out_ready = 1'b1; rst = 1'b0;
    tick("mr_rst", exp_of(vecs[5]));
    rst = 1'b1; in_valid = 1'b0;
    tick("mr_after0", '0);
    tick("mr_after1", '0);

    // NB=8: byte k = k, row offsets 0,1,3,4
    off8 = '{0, 1, 3, 4};
    for (int k = 0; k < 32; k++) in_data8[k*8 +: 8] = 8'(k);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++) begin
        b = 8'(4 * ((c + off8[r]) % 8) + r);
        exp8[(4*c+r)*8 +: 8] = b;
      end
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("nb8 out_valid", {255'd0, out_valid8}, 256'd1);
    chk("nb8 r1c0", {248'd0, out_data8[8 +: 8]}, 256'h05);
    chk("nb8 r3c0", {248'd0, out_data8[24 +: 8]}, 256'h13);
    chk("nb8 state", out_data8, exp8);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("nb8 done", {255'd0, done8}, 256'd1);
    chk("nb8 empty", {255'd0, out_valid8}, 256'd0);
    chk("nb8 zero", out_data8, 256'd0);
    @(posedge clk); #1;
    chk("nb8 done_low", {255'd0, done8}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
